dpram_stream_reader: RTL and testbench
======================================

Name: dpram_stream_reader

Overview:
- Read-side consumer for the dual-port buffer RAMs (IFM total/row buffers, filter buffer).
- On `start`, it issues `len` sequential reads on RAM port B from `base_addr` and absorbs the RAM's N_DELAY read latency.
- Returned words go out as a valid/ready stream with `m_last`.
- A credit-limited skid FIFO guarantees no word is lost under downstream backpressure.

Parameters:
- DW, 32, RAM word width; width of dob and m_data
- AW, 16, RAM address width
- N_DELAY, 1, RAM read latency in enb-qualified cycles (must be >= 1)
- FIFO_DEPTH, 4, skid FIFO entries (must be >= N_DELAY+2; power of two)

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- start  input  1  one-cycle request; sampled only in IDLE
- base_addr  input  AW  first read address, sampled with start
- len  input  AW+1  number of words to read, sampled with start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse after the final word handshake
- enb  output  1  RAM port-B enable
- addrb  output  AW  RAM port-B address
- dob  input  DW  RAM read data
- m_data  output  DW  stream data (FIFO head)
- m_valid  output  1  stream valid
- m_ready  input  1  stream ready
- m_last  output  1  high with the final word of the transfer

Behaviour:
- Reset (rstn low, asynchronous): every output is 0 (busy, done, enb, addrb, m_data, m_valid, m_last). FIFO, counters and tag pipe are cleared and the FSM returns to IDLE. Reset mid-transfer abandons it with no done pulse.
- FSM states:
  - IDLE: start=1 with len>0 latches base_addr and len and goes to RUN. start=1 with len=0 goes to DONE (no reads).
  - RUN: issues reads. When the issue counter reaches len, goes to DRAIN.
  - DRAIN: waits until all in-flight reads are captured and the FIFO is empty with the last word accepted, then goes to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - start outside IDLE is ignored.
- Issue rule (RUN only):
  - `issue = (issued < len) && (fifo_count + inflight < FIFO_DEPTH)`.
  - On issue, addrb = next address, and the address increments modulo 2^AW (0xFFFF wraps to 0x0000).
- RAM pipe advance rule:
  - The RAM pipe only advances on enb-high cycles, so `enb = issue || (inflight > 0)`.
  - Non-issue enb cycles are dummy reads: addrb holds, tag 0.
- Tag pipe:
  - vld_tag[N_DELAY-1:0] shifts on every enb cycle, with stage0 <= issue.
  - inflight = popcount(vld_tag).
  - fresh <= enb (registered).
- Capture: in a cycle with fresh && vld_tag[N_DELAY-1], dob is written into the FIFO.
  - A tag held across an enb-low cycle is never captured twice.
- Stream output:
  - m_valid = (fifo_count > 0).
  - A pop occurs on m_valid && m_ready.
  - m_data and m_valid must hold stable while m_valid=1 and m_ready=0.
  - m_last = m_valid && (popped == len-1).
  - Simultaneous push and pop in the same cycle leave fifo_count unchanged.
- FIFO invariants: the credit rule makes overflow impossible, which is checked by assertion; underflow is impossible by the pop definition.
- Latency (N_DELAY=1, m_ready=1):
  - start sampled at edge 0.
  - First enb/addrb in cycle 1.
  - First m_valid in cycle 3.
  - Sustained 1 word/cycle.
  - done 1 cycle after the final handshake.
- Widths: issued and popped counters are AW+1 bits, so len = 2^AW is legal. len > 2^AW is not supported.

Test Plan:
- len=4, base=0x0010, N_DELAY=1, m_ready=1 -> addrb 0x10..0x13 in cycles 1-4; m_data=RAM[0x10..0x13] in cycles 3-6; m_last with the 4th word; done in cycle 7; busy deasserts with done.
- len=3, base=0xFFFE -> addrb sequence FFFE, FFFF, 0000; data order preserved; m_last on the RAM[0x0000] word.
- len=16, m_ready toggling (1,0,0,1 pattern plus a 10-cycle stall) -> no word lost or duplicated; m_data stable during stall; fifo_count never exceeds FIFO_DEPTH; enb drops while credits are exhausted.
- N_DELAY=3, FIFO_DEPTH=8, len=8, one forced enb-low gap (m_ready=0) -> all 8 words correct, each captured exactly once; dummy enb cycles present in DRAIN.
- len=0 start -> no enb; done pulses 1 cycle after start with busy staying low; a second start issued while busy (len=5 transfer) is ignored.
- rstn pulled low mid-transfer after 2 of 6 words -> all outputs 0 asynchronously with no done pulse; a new start with len=2 afterwards completes normally.

Source files
------------

// File: rtl/dpram_stream_reader.sv
// Streams a block of sequential dual-port RAM reads out as a valid/ready stream.
// Reads are credit-limited so the skid FIFO can always absorb every word in flight.
module dpram_stream_reader #(
  parameter int DW         = 32,
  parameter int AW         = 16,
  parameter int N_DELAY    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          enb,
  output logic [AW-1:0] addrb,
  input  logic [DW-1:0] dob,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last
);

  localparam int IW = $clog2(N_DELAY + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = CW + IW;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

  state_t              state, state_nx;
  logic [AW:0]         len_q;
  logic [AW:0]         issued;
  logic [AW:0]         popped;
  logic [AW-1:0]       addr_q;
  logic [AW-1:0]       addr_hold;
  logic [N_DELAY-1:0]  vld_tag;
  logic                fresh;
  logic [IW-1:0]       inflight;
  logic [CW-1:0]       fifo_count;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [DW-1:0]       fifo_mem [FIFO_DEPTH];
  logic                issue;
  logic                push;
  logic                pop;
  logic                final_pop;

  function automatic logic [IW-1:0] popcount(input logic [N_DELAY-1:0] v);
    logic [IW-1:0] c;
    c = '0;
    for (int i = 0; i < N_DELAY; i++) c = c + IW'(v[i]);
    return c;
  endfunction

  always_comb inflight = popcount(vld_tag);

  // Issue stage: a read goes out only when a FIFO slot is reserved for its data
  assign issue = (state == RUN) && (issued < len_q) &&
                 ((SW'(fifo_count) + SW'(inflight)) < SW'(FIFO_DEPTH));
  assign enb   = issue || (inflight != '0);
  assign addrb = issue ? addr_q : addr_hold;

  // Capture stage: fresh guards against re-capturing a tag parked over an enb-low cycle
  assign push      = fresh && vld_tag[N_DELAY-1];
  assign m_valid   = (fifo_count != '0);
  assign pop       = m_valid && m_ready;
  assign m_data    = m_valid ? fifo_mem[rd_ptr] : '0;
  assign m_last    = m_valid && (popped == len_q - 1'b1);
  assign final_pop = pop && m_last && (inflight == '0);
  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == FINISH);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (len == '0) ? FINISH : RUN;
      RUN:     if (issue && (issued + 1'b1 == len_q)) state_nx = DRAIN;
      DRAIN:   if (final_pop) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      len_q      <= '0;
      issued     <= '0;
      popped     <= '0;
      addr_q     <= '0;
      addr_hold  <= '0;
      vld_tag    <= '0;
      fresh      <= 1'b0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        len_q  <= len;
        addr_q <= base_addr;
        issued <= '0;
        popped <= '0;
      end
      if (issue) begin
        issued    <= issued + 1'b1;
        addr_q    <= addr_q + 1'b1;
        addr_hold <= addr_q;
      end
      if (pop) begin
        popped <= popped + 1'b1;
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (enb) vld_tag <= (vld_tag << 1) | N_DELAY'(issue);
      fresh <= enb;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage stage: data only, no reset needed since m_data is gated by m_valid
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= dob;
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(push && !pop && (fifo_count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Directed bench for dpram_stream_reader: a 1-cycle-latency instance and a
// 3-cycle-latency instance, each fed by a small RAM model.
module tb_dpram_stream_reader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;

  logic        start1 = 1'b0, start2 = 1'b0;
  logic [15:0] base1 = '0, base2 = '0;
  logic [16:0] len1 = '0, len2 = '0;
  logic        busy1, done1, enb1, mvalid1, mlast1;
  logic        busy2, done2, enb2, mvalid2, mlast2;
  logic [15:0] addrb1, addrb2;
  logic [31:0] dob1, dob2, mdata1, mdata2;
  logic        mready1 = 1'b1, mready2 = 1'b1;
  logic [31:0] r2_0, r2_1;

  int checks = 0;
  int errors = 0;

  logic [32:0] q1[$];
  logic [32:0] q2[$];
  int enb_cnt1 = 0, done_cnt1 = 0, enb_cnt2 = 0, done_cnt2 = 0;
  int max_cnt1 = 0;
  logic        stall1 = 1'b0, stall2 = 1'b0;
  logic [31:0] sdata1 = '0, sdata2 = '0;

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [15:0] a);
    return {a ^ 16'hA5A5, a};
  endfunction

  always_ff @(posedge clk) if (enb1) dob1 <= ram_word(addrb1);

  always_ff @(posedge clk) begin
    if (enb2) begin
      r2_0 <= ram_word(addrb2);
      r2_1 <= r2_0;
      dob2 <= r2_1;
    end
  end

  dpram_stream_reader #(.DW(32), .AW(16), .N_DELAY(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rstn(rstn), .start(start1), .base_addr(base1), .len(len1),
    .busy(busy1), .done(done1), .enb(enb1), .addrb(addrb1), .dob(dob1),
    .m_data(mdata1), .m_valid(mvalid1), .m_ready(mready1), .m_last(mlast1));

  dpram_stream_reader #(.DW(32), .AW(16), .N_DELAY(3), .FIFO_DEPTH(8)) dut2 (
    .clk(clk), .rstn(rstn), .start(start2), .base_addr(base2), .len(len2),
    .busy(busy2), .done(done2), .enb(enb2), .addrb(addrb2), .dob(dob2),
    .m_data(mdata2), .m_valid(mvalid2), .m_ready(mready2), .m_last(mlast2));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer1(input logic [15:0] b, input logic [16:0] l);
    start1 = 1'b1; base1 = b; len1 = l;
    step();
    start1 = 1'b0;
  endtask

  task automatic wait_done1(input string name, input int limit);
    int n;
    n = 0;
    #1;
    while (!done1 && n < limit) begin
      step();
      #1;
      n++;
    end
    chk(name, done1, 1'b1);
  endtask

  task automatic check_stream(input string name, input logic [32:0] q[$],
                              input logic [15:0] b, input int n);
    chk({name, "_count"}, q.size(), n);
    for (int i = 0; i < n && i < q.size(); i++)
      chk(name, q[i], {(i == n - 1), ram_word(b + 16'(i))});
  endtask

  // stream monitors: record handshakes, check hold-under-stall
  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      stall1 = 1'b0;
      stall2 = 1'b0;
    end else begin
      if (stall1) begin
        chk("stall1_valid", mvalid1, 1'b1);
        chk("stall1_data", mdata1, sdata1);
      end
      if (stall2) begin
        chk("stall2_valid", mvalid2, 1'b1);
        chk("stall2_data", mdata2, sdata2);
      end
      if (mvalid1 && mready1) q1.push_back({mlast1, mdata1});
      if (mvalid2 && mready2) q2.push_back({mlast2, mdata2});
      stall1 = mvalid1 && !mready1; sdata1 = mdata1;
      stall2 = mvalid2 && !mready2; sdata2 = mdata2;
      if (enb1) enb_cnt1++;
      if (done1) done_cnt1++;
      if (enb2) enb_cnt2++;
      if (done2) done_cnt2++;
      if (int'(dut1.fifo_count) > max_cnt1) max_cnt1 = int'(dut1.fifo_count);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  typedef struct {
    logic        rdy;
    logic        enb;
    logic        chk_addr;
    logic [15:0] addr;
    logic        vld;
    logic [31:0] data;
    logic        last;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tv[8];
  logic [15:0] wrap_a[3];

  initial begin
    tv[0] = '{1'b1, 1'b1, 1'b1, 16'h0010, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
    tv[1] = '{1'b1, 1'b1, 1'b1, 16'h0011, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
    tv[2] = '{1'b1, 1'b1, 1'b1, 16'h0012, 1'b1, ram_word(16'h0010), 1'b0, 1'b1, 1'b0};
    tv[3] = '{1'b1, 1'b1, 1'b1, 16'h0013, 1'b1, ram_word(16'h0011), 1'b0, 1'b1, 1'b0};
    tv[4] = '{1'b1, 1'b1, 1'b1, 16'h0013, 1'b1, ram_word(16'h0012), 1'b0, 1'b1, 1'b0};
    tv[5] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, ram_word(16'h0013), 1'b1, 1'b1, 1'b0};
    tv[6] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1};
    tv[7] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
    wrap_a[0] = 16'hFFFE; wrap_a[1] = 16'hFFFF; wrap_a[2] = 16'h0000;

    // reset state
    #3;
    chk("rst_busy1", busy1, 1'b0);   chk("rst_done1", done1, 1'b0);
    chk("rst_enb1", enb1, 1'b0);     chk("rst_addrb1", addrb1, 16'h0);
    chk("rst_mdata1", mdata1, 32'h0); chk("rst_mvalid1", mvalid1, 1'b0);
    chk("rst_mlast1", mlast1, 1'b0);
    chk("rst_busy2", busy2, 1'b0);   chk("rst_enb2", enb2, 1'b0);
    chk("rst_mvalid2", mvalid2, 1'b0); chk("rst_mlast2", mlast2, 1'b0);
    step(); step();
    rstn = 1'b1;
    step();

    // len=4 cycle-exact table
    q1.delete();
    start_xfer1(16'h0010, 17'd4);
    for (int i = 0; i < 8; i++) begin
      mready1 = tv[i].rdy;
      #1;
      chk($sformatf("t1_c%0d_enb", i + 1), enb1, tv[i].enb);
      if (tv[i].chk_addr) chk($sformatf("t1_c%0d_addrb", i + 1), addrb1, tv[i].addr);
      chk($sformatf("t1_c%0d_valid", i + 1), mvalid1, tv[i].vld);
      if (tv[i].vld) chk($sformatf("t1_c%0d_data", i + 1), mdata1, tv[i].data);
      chk($sformatf("t1_c%0d_last", i + 1), mlast1, tv[i].last);
      chk($sformatf("t1_c%0d_busy", i + 1), busy1, tv[i].busy);
      chk($sformatf("t1_c%0d_done", i + 1), done1, tv[i].done);
      step();
    end
    check_stream("t1_stream", q1, 16'h0010, 4);

    // address wrap
    q1.delete();
    start_xfer1(16'hFFFE, 17'd3);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_enb", enb1, 1'b1);
      chk("t2_addrb", addrb1, wrap_a[i]);
      step();
    end
    wait_done1("t2_done", 50);
    step();
    check_stream("t2_stream", q1, 16'hFFFE, 3);

    // backpressure with long stall
    q1.delete();
    max_cnt1 = 0;
    done_cnt1 = 0;
    start_xfer1(16'h0100, 17'd16);
    for (int c = 1; c < 300; c++) begin
      mready1 = (c >= 8 && c <= 17) ? 1'b0 : ((c % 4 == 0) || (c % 4 == 3));
      #1;
      if (c == 17) begin
        chk("t3_enb_low_no_credit", enb1, 1'b0);
        chk("t3_busy_in_stall", busy1, 1'b1);
      end
      if (done1) break;
      step();
    end
    chk("t3_done", done1, 1'b1);
    mready1 = 1'b1;
    step();
    check_stream("t3_stream", q1, 16'h0100, 16);
    chk("t3_fifo_peak", max_cnt1, 4);
    chk("t3_done_once", done_cnt1, 1);

    // N_DELAY=3 with forced enb-low gap
    q2.delete();
    enb_cnt2 = 0;
    done_cnt2 = 0;
    mready2 = 1'b0;
    start2 = 1'b1; base2 = 16'h0400; len2 = 17'd8;
    step();
    start2 = 1'b0;
    for (int c = 1; c < 300; c++) begin
      mready2 = (c >= 15);
      #1;
      if (c >= 9 && c <= 11) begin
        chk("t4_drain_dummy_enb", enb2, 1'b1);
        chk("t4_drain_busy", busy2, 1'b1);
      end
      if (c == 10) chk("t4_dummy_addr_hold", addrb2, 16'h0407);
      if (c == 13) begin
        chk("t4_gap_enb_low", enb2, 1'b0);
        chk("t4_gap_busy", busy2, 1'b1);
        chk("t4_gap_valid", mvalid2, 1'b1);
      end
      if (done2) break;
      step();
    end
    chk("t4_done", done2, 1'b1);
    mready2 = 1'b1;
    step();
    check_stream("t4_stream", q2, 16'h0400, 8);
    chk("t4_enb_cycles", enb_cnt2, 11);
    chk("t4_done_once", done_cnt2, 1);

    // len=0 and start while busy
    enb_cnt1 = 0;
    start_xfer1(16'h0050, 17'd0);
    #1;
    chk("t5_len0_done", done1, 1'b1);
    chk("t5_len0_busy", busy1, 1'b0);
    chk("t5_len0_enb", enb1, 1'b0);
    step();
    #1;
    chk("t5_len0_done_pulse", done1, 1'b0);
    chk("t5_len0_no_reads", enb_cnt1, 0);
    step();
    q1.delete();
    done_cnt1 = 0;
    start_xfer1(16'h0500, 17'd5);
    step();
    start_xfer1(16'h0600, 17'd2);
    wait_done1("t5_done", 50);
    step();
    check_stream("t5_stream", q1, 16'h0500, 5);
    chk("t5_done_once", done_cnt1, 1);

    // asynchronous reset mid-transfer
    q1.delete();
    done_cnt1 = 0;
    start_xfer1(16'h0200, 17'd6);
    begin
      int n;
      n = 0;
      while (q1.size() < 2 && n < 20) begin
        step();
        n++;
      end
    end
    chk("t6_words_before_reset", q1.size(), 2);
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_busy", busy1, 1'b0);   chk("t6_done", done1, 1'b0);
    chk("t6_enb", enb1, 1'b0);     chk("t6_addrb", addrb1, 16'h0);
    chk("t6_mdata", mdata1, 32'h0); chk("t6_mvalid", mvalid1, 1'b0);
    chk("t6_mlast", mlast1, 1'b0);
    step(); step();
    rstn = 1'b1;
    step(); step();
    chk("t6_no_done_after_abort", done_cnt1, 0);
    q1.delete();
    start_xfer1(16'h0300, 17'd2);
    wait_done1("t6_restart_done", 50);
    step();
    check_stream("t6_restart_stream", q1, 16'h0300, 2);
    chk("t6_restart_done_once", done_cnt1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
